tnet_cmd_arbiter: RTL and testbench



---
 rtl/tnet_pkg.sv | 22 ++
 rtl/tnet_arb_timer.sv | 36 +++
 rtl/tnet_cmd_arbiter.sv | 171 +++++++++++++++++
 tb/tb_tnet_cmd_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tnet_pkg.sv
// Shared types and constants for the tnet command arbiter.
package tnet_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ERROR = 2'd3
  } TYPE_ARB_ST;

  localparam logic SRC_LOC = 1'b0;
  localparam logic SRC_NET = 1'b1;

  localparam logic [3:0] ERR_ID_TMO = 4'hF;

  // 8-bit increment that sticks at all-ones
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tnet_arb_timer.sv
// Command watchdog timer: saturating up-counter with a limit compare.
// expired_o flags the cycle in which the count reaches limit-1, so a
// timeout fires after exactly `limit` counted cycles from the clear.
module tnet_arb_timer #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         cmp_en_i,
  input  logic [W-1:0] limit_i,
  output logic         expired_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;

  // Count enabled cycles; hold at all-ones so a long command never wraps into a false match
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + ONE;
    end
  end

  // A zero limit disables the watchdog; the compare uses the live limit value
  always_comb begin
    expired_o = cmp_en_i && (limit_i != '0) && (cnt_q == (limit_i - ONE));
  end

endmodule

// File: rtl/tnet_cmd_arbiter.sv
// Arbitrates the tnet command engine between the local (PS) and network
// requesters, tracks the granted command to completion, and records
// error / timeout status for software.
//
// state | meaning
// IDLE  | no command in flight; grant a requester if any is valid
// ISSUE | granted command offered to engine, waiting for eng_rdy_i
// WAIT  | engine owns the command, waiting for done / error / timeout
// ERROR | engine error or timeout recorded; hold until clr_i
module tnet_cmd_arbiter
  import tnet_pkg::*;
#(
  parameter int OP_W  = 5,
  parameter int DT_W  = 32,
  parameter int TMO_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             loc_vld_i,
  input  logic [OP_W-1:0]  loc_op_i,
  input  logic [DT_W-1:0]  loc_dt_i,
  output logic             loc_rdy_o,
  input  logic             net_vld_i,
  input  logic [OP_W-1:0]  net_op_i,
  input  logic [DT_W-1:0]  net_dt_i,
  output logic             net_rdy_o,
  output logic             eng_vld_o,
  output logic [OP_W-1:0]  eng_op_o,
  output logic [DT_W-1:0]  eng_dt_o,
  output logic             eng_src_o,
  input  logic             eng_rdy_i,
  input  logic             eng_done_i,
  input  logic             eng_err_i,
  input  logic [3:0]       eng_err_id_i,
  input  logic             prio_net_i,
  input  logic [TMO_W-1:0] tmo_cyc_i,
  input  logic             clr_i,
  output logic             busy_o,
  output logic             err_o,
  output logic [3:0]       err_id_o,
  output logic [15:0]      cmd_cnt_o,
  output logic [7:0]       tmo_cnt_o
);

  TYPE_ARB_ST      state_q, state_d;
  logic [OP_W-1:0] op_q;
  logic [DT_W-1:0] dt_q;
  logic            src_q;
  logic            last_src_q;
  logic            err_q;
  logic [3:0]      err_id_q;
  logic [15:0]     cmd_cnt_q;
  logic [7:0]      tmo_cnt_q;

  logic net_win, loc_win, grant;
  logic active, tmo_exp;
  logic err_evt, tmo_evt, done_evt;

  // Winner selection; grants are suppressed while reset is asserted so rdy reads 0 in reset
  always_comb begin
    net_win   = net_vld_i && (!loc_vld_i || prio_net_i || (last_src_q == SRC_LOC));
    loc_win   = loc_vld_i && !net_win;
    loc_rdy_o = rst_ni && (state_q == IDLE) && loc_win;
    net_rdy_o = rst_ni && (state_q == IDLE) && net_win;
    grant     = loc_rdy_o || net_rdy_o;
  end

  // Timer runs only while a command is in flight
  always_comb begin
    active = (state_q == ISSUE) || (state_q == WAIT);
  end

  tnet_arb_timer #(.W(TMO_W)) u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (grant),
    .en_i      (active),
    .cmp_en_i  (active),
    .limit_i   (tmo_cyc_i),
    .expired_o (tmo_exp)
  );

  // Completion events; engine error outranks done, which outranks the watchdog
  always_comb begin
    err_evt  = (state_q == WAIT) && eng_err_i;
    done_evt = (state_q == WAIT) && !eng_err_i && eng_done_i;
    tmo_evt  = tmo_exp && ((state_q == ISSUE) ||
                           ((state_q == WAIT) && !eng_err_i && !eng_done_i));
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = ISSUE;
      ISSUE: begin
        if (tmo_evt)        state_d = ERROR;
        else if (eng_rdy_i) state_d = WAIT;
      end
      WAIT: begin
        if (err_evt || tmo_evt) state_d = ERROR;
        else if (done_evt)      state_d = IDLE;
      end
      ERROR:   if (clr_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Capture the granted command and remember its source for round-robin
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q       <= '0;
      dt_q       <= '0;
      src_q      <= SRC_LOC;
      last_src_q <= SRC_LOC;
    end else if (grant) begin
      op_q       <= net_win ? net_op_i : loc_op_i;
      dt_q       <= net_win ? net_dt_i : loc_dt_i;
      src_q      <= net_win ? SRC_NET : SRC_LOC;
      last_src_q <= net_win ? SRC_NET : SRC_LOC;
    end
  end

  // Sticky error status; a same-cycle error event beats clr_i
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q    <= 1'b0;
      err_id_q <= 4'h0;
    end else if (err_evt) begin
      err_q    <= 1'b1;
      err_id_q <= eng_err_id_i;
    end else if (tmo_evt) begin
      err_q    <= 1'b1;
      err_id_q <= ERR_ID_TMO;
    end else if (clr_i) begin
      err_q    <= 1'b0;
      err_id_q <= 4'h0;
    end
  end

  // Statistics: completed commands wrap, timeouts saturate; clr_i leaves both alone
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_cnt_q <= 16'd0;
      tmo_cnt_q <= 8'd0;
    end else begin
      if (done_evt) cmd_cnt_q <= cmd_cnt_q + 16'd1;
      if (tmo_evt)  tmo_cnt_q <= sat_inc8(tmo_cnt_q);
    end
  end

  // Output mapping
  always_comb begin
    eng_vld_o = (state_q == ISSUE);
    eng_op_o  = op_q;
    eng_dt_o  = dt_q;
    eng_src_o = src_q;
    busy_o    = (state_q != IDLE);
    err_o     = err_q;
    err_id_o  = err_id_q;
    cmd_cnt_o = cmd_cnt_q;
    tmo_cnt_o = tmo_cnt_q;
  end

endmodule

// File: tb/tb_tnet_cmd_arbiter.sv
// Directed bench for tnet_cmd_arbiter: inputs change 1 ns after the rising
// edge, outputs are sampled 2 ns later (well before the next edge).
module tb_tnet_cmd_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        loc_vld_i = 1'b0;
  logic [4:0]  loc_op_i = '0;
  logic [31:0] loc_dt_i = '0;
  logic        loc_rdy_o;
  logic        net_vld_i = 1'b0;
  logic [4:0]  net_op_i = '0;
  logic [31:0] net_dt_i = '0;
  logic        net_rdy_o;
  logic        eng_vld_o;
  logic [4:0]  eng_op_o;
  logic [31:0] eng_dt_o;
  logic        eng_src_o;
  logic        eng_rdy_i = 1'b0;
  logic        eng_done_i = 1'b0;
  logic        eng_err_i = 1'b0;
  logic [3:0]  eng_err_id_i = '0;
  logic        prio_net_i = 1'b0;
  logic [15:0] tmo_cyc_i = '0;
  logic        clr_i = 1'b0;
  logic        busy_o;
  logic        err_o;
  logic [3:0]  err_id_o;
  logic [15:0] cmd_cnt_o;
  logic [7:0]  tmo_cnt_o;

  int checks = 0;
  int failures = 0;

  tnet_cmd_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .loc_vld_i(loc_vld_i), .loc_op_i(loc_op_i), .loc_dt_i(loc_dt_i), .loc_rdy_o(loc_rdy_o),
    .net_vld_i(net_vld_i), .net_op_i(net_op_i), .net_dt_i(net_dt_i), .net_rdy_o(net_rdy_o),
    .eng_vld_o(eng_vld_o), .eng_op_o(eng_op_o), .eng_dt_o(eng_dt_o), .eng_src_o(eng_src_o),
    .eng_rdy_i(eng_rdy_i), .eng_done_i(eng_done_i), .eng_err_i(eng_err_i),
    .eng_err_id_i(eng_err_id_i), .prio_net_i(prio_net_i), .tmo_cyc_i(tmo_cyc_i),
    .clr_i(clr_i), .busy_o(busy_o), .err_o(err_o), .err_id_o(err_id_o),
    .cmd_cnt_o(cmd_cnt_o), .tmo_cnt_o(tmo_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Finish an accepted command: ISSUE -> WAIT -> IDLE via done
  task automatic finish_cmd();
    eng_rdy_i = 1'b1;
    step();
    eng_rdy_i = 1'b0;
    eng_done_i = 1'b1;
    step();
    eng_done_i = 1'b0;
  endtask

  task automatic test_reset();
    loc_vld_i = 1'b1;
    #3;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy_o); end
    checks++; if (eng_vld_o !== 1'b0 || eng_op_o !== 5'd0 || eng_dt_o !== 32'd0 || eng_src_o !== 1'b0) begin failures++; $display("FAIL reset_eng got=%0h/%0h/%0h/%0h exp=0", eng_vld_o, eng_op_o, eng_dt_o, eng_src_o); end
    checks++; if (err_o !== 1'b0 || err_id_o !== 4'h0) begin failures++; $display("FAIL reset_err got=%0h/%0h exp=0", err_o, err_id_o); end
    checks++; if (cmd_cnt_o !== 16'd0 || tmo_cnt_o !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0h/%0h exp=0", cmd_cnt_o, tmo_cnt_o); end
    checks++; if (loc_rdy_o !== 1'b0 || net_rdy_o !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%0h/%0h exp=0", loc_rdy_o, net_rdy_o); end
    loc_vld_i = 1'b0;
    step();
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_single_loc();
    loc_vld_i = 1'b1; loc_op_i = 5'd6; loc_dt_i = 32'h1234;
    #2;
    checks++; if (loc_rdy_o !== 1'b1 || net_rdy_o !== 1'b0) begin failures++; $display("FAIL single_rdy got=%0h/%0h exp=1/0", loc_rdy_o, net_rdy_o); end
    checks++; if (eng_vld_o !== 1'b0) begin failures++; $display("FAIL single_vld_n got=%0h exp=0", eng_vld_o); end
    step();
    loc_vld_i = 1'b0;
    #2;
    checks++; if (eng_vld_o !== 1'b1 || eng_op_o !== 5'd6 || eng_dt_o !== 32'h1234 || eng_src_o !== 1'b0) begin failures++; $display("FAIL single_issue got=%0h/%0h/%0h/%0h exp=1/6/1234/0", eng_vld_o, eng_op_o, eng_dt_o, eng_src_o); end
    checks++; if (loc_rdy_o !== 1'b0 || busy_o !== 1'b1) begin failures++; $display("FAIL single_busy got=%0h/%0h exp=0/1", loc_rdy_o, busy_o); end
    step();
    #2;
    checks++; if (eng_vld_o !== 1'b1 || eng_op_o !== 5'd6) begin failures++; $display("FAIL single_hold got=%0h/%0h exp=1/6", eng_vld_o, eng_op_o); end
    step();
    eng_rdy_i = 1'b1;
    step();
    eng_rdy_i = 1'b0;
    #2;
    checks++; if (eng_vld_o !== 1'b0 || busy_o !== 1'b1) begin failures++; $display("FAIL single_wait got=%0h/%0h exp=0/1", eng_vld_o, busy_o); end
    eng_done_i = 1'b1;
    step();
    eng_done_i = 1'b0;
    #2;
    checks++; if (busy_o !== 1'b0 || cmd_cnt_o !== 16'd1) begin failures++; $display("FAIL single_done got=%0h/%0h exp=0/1", busy_o, cmd_cnt_o); end
  endtask

  task automatic test_round_robin();
    logic exp_net;
    prio_net_i = 1'b0;
    loc_vld_i = 1'b1; loc_op_i = 5'd1; loc_dt_i = 32'h11;
    net_vld_i = 1'b1; net_op_i = 5'd2; net_dt_i = 32'h22;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) prio_net_i = 1'b1;
      exp_net = (i >= 4) || (i % 2 == 0);
      #1;
      checks++; if (net_rdy_o !== exp_net || loc_rdy_o !== !exp_net) begin failures++; $display("FAIL arb_grant_%0d got=net%0h/loc%0h exp=net%0h", i, net_rdy_o, loc_rdy_o, exp_net); end
      step();
      checks++; if (eng_src_o !== exp_net || eng_op_o !== (exp_net ? 5'd2 : 5'd1)) begin failures++; $display("FAIL arb_src_%0d got=%0h/%0h exp=%0h", i, eng_src_o, eng_op_o, exp_net); end
      finish_cmd();
    end
    loc_vld_i = 1'b0; net_vld_i = 1'b0; prio_net_i = 1'b0;
    #2;
    checks++; if (cmd_cnt_o !== 16'd8) begin failures++; $display("FAIL arb_cnt got=%0d exp=8", cmd_cnt_o); end
  endtask

  task automatic test_timeout();
    tmo_cyc_i = 16'd10;
    loc_vld_i = 1'b1; loc_op_i = 5'd3; loc_dt_i = 32'h33;
    step();
    eng_rdy_i = 1'b1;
    #2;
    checks++; if (loc_rdy_o !== 1'b0) begin failures++; $display("FAIL tmo_rdy_issue got=%0h exp=0", loc_rdy_o); end
    for (int k = 1; k <= 10; k++) begin
      step();
      eng_rdy_i = 1'b0;
      #2;
      checks++; if (err_o !== (k == 10) || loc_rdy_o !== 1'b0) begin failures++; $display("FAIL tmo_cycle_%0d got=err%0h/rdy%0h exp=err%0h", k, err_o, loc_rdy_o, (k == 10)); end
    end
    checks++; if (err_id_o !== 4'hF || tmo_cnt_o !== 8'd1 || busy_o !== 1'b1 || eng_vld_o !== 1'b0) begin failures++; $display("FAIL tmo_status got=%0h/%0h/%0h/%0h exp=f/1/1/0", err_id_o, tmo_cnt_o, busy_o, eng_vld_o); end
    step(); step();
    #2;
    checks++; if (loc_rdy_o !== 1'b0 || busy_o !== 1'b1 || err_o !== 1'b1) begin failures++; $display("FAIL tmo_hold got=%0h/%0h/%0h exp=0/1/1", loc_rdy_o, busy_o, err_o); end
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    #2;
    checks++; if (busy_o !== 1'b0 || err_o !== 1'b0 || err_id_o !== 4'h0 || loc_rdy_o !== 1'b1) begin failures++; $display("FAIL tmo_clr got=%0h/%0h/%0h/%0h exp=0/0/0/1", busy_o, err_o, err_id_o, loc_rdy_o); end
    checks++; if (tmo_cnt_o !== 8'd1) begin failures++; $display("FAIL tmo_cnt_kept got=%0d exp=1", tmo_cnt_o); end
    step();
    loc_vld_i = 1'b0;
    finish_cmd();
    tmo_cyc_i = 16'd0;
    #2;
    checks++; if (cmd_cnt_o !== 16'd9) begin failures++; $display("FAIL tmo_regrant got=%0d exp=9", cmd_cnt_o); end
  endtask

  task automatic test_err_vs_done();
    loc_vld_i = 1'b1; loc_op_i = 5'd4; loc_dt_i = 32'h44;
    step();
    loc_vld_i = 1'b0;
    eng_rdy_i = 1'b1;
    step();
    eng_rdy_i = 1'b0;
    eng_done_i = 1'b1; eng_err_i = 1'b1; eng_err_id_i = 4'h3; clr_i = 1'b1;
    step();
    eng_done_i = 1'b0; eng_err_i = 1'b0; eng_err_id_i = 4'h0; clr_i = 1'b0;
    #2;
    checks++; if (err_o !== 1'b1 || err_id_o !== 4'h3 || busy_o !== 1'b1) begin failures++; $display("FAIL errdone_status got=%0h/%0h/%0h exp=1/3/1", err_o, err_id_o, busy_o); end
    checks++; if (cmd_cnt_o !== 16'd9) begin failures++; $display("FAIL errdone_cnt got=%0d exp=9", cmd_cnt_o); end
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    #2;
    checks++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin failures++; $display("FAIL errdone_clr got=%0h/%0h exp=0/0", busy_o, err_o); end
  endtask

  task automatic test_reset_in_wait();
    loc_vld_i = 1'b1; loc_op_i = 5'd9; loc_dt_i = 32'hAB;
    step();
    loc_vld_i = 1'b0;
    eng_rdy_i = 1'b1;
    step();
    eng_rdy_i = 1'b0;
    loc_vld_i = 1'b1; loc_op_i = 5'd10; loc_dt_i = 32'hCD;
    #1;
    checks++; if (loc_rdy_o !== 1'b0 || busy_o !== 1'b1) begin failures++; $display("FAIL rstw_pre got=%0h/%0h exp=0/1", loc_rdy_o, busy_o); end
    rst_ni = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0 || eng_op_o !== 5'd0 || eng_dt_o !== 32'd0 || cmd_cnt_o !== 16'd0 || tmo_cnt_o !== 8'd0 || loc_rdy_o !== 1'b0) begin failures++; $display("FAIL rstw_async got=%0h/%0h/%0h/%0h/%0h/%0h exp=0", busy_o, eng_op_o, eng_dt_o, cmd_cnt_o, tmo_cnt_o, loc_rdy_o); end
    step();
    rst_ni = 1'b1;
    #1;
    checks++; if (loc_rdy_o !== 1'b1 || busy_o !== 1'b0) begin failures++; $display("FAIL rstw_regrant got=%0h/%0h exp=1/0", loc_rdy_o, busy_o); end
    step();
    loc_vld_i = 1'b0;
    #1;
    checks++; if (eng_vld_o !== 1'b1 || eng_op_o !== 5'd10 || eng_dt_o !== 32'hCD || eng_src_o !== 1'b0) begin failures++; $display("FAIL rstw_issue got=%0h/%0h/%0h/%0h exp=1/a/cd/0", eng_vld_o, eng_op_o, eng_dt_o, eng_src_o); end
    finish_cmd();
    #1;
    checks++; if (cmd_cnt_o !== 16'd1) begin failures++; $display("FAIL rstw_cnt got=%0d exp=1", cmd_cnt_o); end
  endtask

  task automatic test_long_and_saturate();
    tmo_cyc_i = 16'd0;
    loc_vld_i = 1'b1; loc_op_i = 5'd7; loc_dt_i = 32'h77;
    step();
    loc_vld_i = 1'b0;
    eng_rdy_i = 1'b1;
    step();
    eng_rdy_i = 1'b0;
    for (int k = 0; k < 70000; k++) step();
    #1;
    checks++; if (busy_o !== 1'b1 || err_o !== 1'b0 || tmo_cnt_o !== 8'd0) begin failures++; $display("FAIL long_no_tmo got=%0h/%0h/%0h exp=1/0/0", busy_o, err_o, tmo_cnt_o); end
    eng_done_i = 1'b1;
    step();
    eng_done_i = 1'b0;
    #1;
    checks++; if (cmd_cnt_o !== 16'd2 || busy_o !== 1'b0) begin failures++; $display("FAIL long_done got=%0h/%0h exp=2/0", cmd_cnt_o, busy_o); end
    tmo_cyc_i = 16'd2;
    for (int i = 0; i < 256; i++) begin
      loc_vld_i = 1'b1;
      step();
      loc_vld_i = 1'b0;
      step();
      step();
      #1;
      if (i == 0) begin
        checks++; if (err_o !== 1'b1 || err_id_o !== 4'hF || tmo_cnt_o !== 8'd1) begin failures++; $display("FAIL sat_first got=%0h/%0h/%0h exp=1/f/1", err_o, err_id_o, tmo_cnt_o); end
      end
      if (i == 254 || i == 255) begin
        checks++; if (tmo_cnt_o !== 8'd255) begin failures++; $display("FAIL sat_cnt_%0d got=%0d exp=255", i, tmo_cnt_o); end
      end
      clr_i = 1'b1;
      step();
      clr_i = 1'b0;
    end
    tmo_cyc_i = 16'd0;
    #1;
    checks++; if (busy_o !== 1'b0 || cmd_cnt_o !== 16'd2) begin failures++; $display("FAIL sat_end got=%0h/%0h exp=0/2", busy_o, cmd_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_single_loc();
    test_round_robin();
    test_timeout();
    test_err_vs_done();
    test_reset_in_wait();
    test_long_and_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
